// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter with synchronous clear/load, wrap or saturate at the limits,
// a registered carry/borrow pulse for cascading and a sticky overflow flag.
module up_down_counter_mod #(
    parameter int unsigned     WIDTH       = 4,
    parameter longint unsigned MODULUS     = 16,
    parameter bit              SATURATE    = 1'b0,
    parameter longint unsigned RESET_VALUE = 0
) (
    input  logic             BrdClk,
    input  logic             aReset,
    input  logic             aClear,
    input  logic             aLoad,
    input  logic [WIDTH-1:0] aLoadValue,
    input  logic             aEnable,
    input  logic             aUp,
    input  logic             aStickyClr,
    output logic [WIDTH-1:0] bCount,
    output logic             bCarry,
    output logic             bTerminal,
    output logic             bOverflowSticky
);

    // One extra bit so MODULUS = 2**WIDTH still compares correctly.
    localparam int unsigned ExtW = WIDTH + 1;
    localparam logic [ExtW-1:0]  LimitExt = ExtW'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LimitVal = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VALUE);

    logic [ExtW-1:0]  countExt;
    logic [ExtW-1:0]  loadExt;
    logic             atTop;
    logic             atBottom;
    logic [WIDTH-1:0] nextCount;
    logic             nextCarry;
    logic             nextSticky;

    assign countExt = {1'b0, bCount};
    assign loadExt  = {1'b0, aLoadValue};
    assign atTop    = (countExt >= LimitExt);
    assign atBottom = (bCount == '0);

    // Terminal decode follows the live direction so a cascade needs no extra cycle.
    assign bTerminal = aUp ? atTop : atBottom;

    // Next count and carry: clear > load > enable > hold.
    always_comb begin
        nextCount = bCount;
        nextCarry = 1'b0;
        if (aClear) begin
            nextCount = '0;
        end else if (aLoad) begin
            nextCount = (loadExt > LimitExt) ? LimitVal : aLoadValue;
        end else if (aEnable) begin
            if (aUp) begin
                if (atTop) begin
                    nextCarry = 1'b1;
                    nextCount = SATURATE ? LimitVal : '0;
                end else begin
                    nextCount = WIDTH'(countExt + ExtW'(1));
                end
            end else begin
                if (atBottom) begin
                    nextCarry = 1'b1;
                    nextCount = SATURATE ? '0 : LimitVal;
                end else begin
                    nextCount = bCount - WIDTH'(1);
                end
            end
        end
    end

    // A new carry beats a simultaneous sticky clear.
    always_comb begin
        nextSticky = bOverflowSticky;
        if (nextCarry) begin
            nextSticky = 1'b1;
        end else if (aStickyClr) begin
            nextSticky = 1'b0;
        end
    end

    always_ff @(posedge BrdClk or posedge aReset) begin
        if (aReset) begin
            bCount          <= ResetVal;
            bCarry          <= 1'b0;
            bOverflowSticky <= 1'b0;
        end else begin
            bCount          <= nextCount;
            bCarry          <= nextCarry;
            bOverflowSticky <= nextSticky;
        end
    end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Scoreboard bench for up_down_counter_mod: wrap, saturate and a two-stage 16x16 cascade.
module tb_up_down_counter_mod;

    typedef struct {
        int unsigned dut;
        logic [7:0]  cnt;
        logic        carry;
        logic        sticky;
        logic        term;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic BrdClk = 1'b0;
    logic aReset = 1'b1;
    always #5 BrdClk = ~BrdClk;

    // Wrap-mode instance, MODULUS 10
    logic       clr0 = 0, ld0 = 0, en0 = 0, up0 = 0, sc0 = 0;
    logic [3:0] lv0 = 0, cnt0;
    logic       car0, term0, st0;

    // Saturate-mode instance, MODULUS 10
    logic       clr1 = 0, ld1 = 0, en1 = 0, up1 = 0, sc1 = 0;
    logic [3:0] lv1 = 0, cnt1;
    logic       car1, term1, st1;

    // Cascade pair, MODULUS 16
    logic       en2 = 0;
    logic [3:0] cntLo, cntHi;
    logic       carLo, carHi, termLo, termHi, stLo, stHi;

    up_down_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VALUE(0)) u0 (
        .BrdClk(BrdClk), .aReset(aReset), .aClear(clr0), .aLoad(ld0), .aLoadValue(lv0),
        .aEnable(en0), .aUp(up0), .aStickyClr(sc0),
        .bCount(cnt0), .bCarry(car0), .bTerminal(term0), .bOverflowSticky(st0));

    up_down_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VALUE(0)) u1 (
        .BrdClk(BrdClk), .aReset(aReset), .aClear(clr1), .aLoad(ld1), .aLoadValue(lv1),
        .aEnable(en1), .aUp(up1), .aStickyClr(sc1),
        .bCount(cnt1), .bCarry(car1), .bTerminal(term1), .bOverflowSticky(st1));

    up_down_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .RESET_VALUE(0)) uLo (
        .BrdClk(BrdClk), .aReset(aReset), .aClear(1'b0), .aLoad(1'b0), .aLoadValue(4'd0),
        .aEnable(en2), .aUp(1'b1), .aStickyClr(1'b0),
        .bCount(cntLo), .bCarry(carLo), .bTerminal(termLo), .bOverflowSticky(stLo));

    up_down_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .RESET_VALUE(0)) uHi (
        .BrdClk(BrdClk), .aReset(aReset), .aClear(1'b0), .aLoad(1'b0), .aLoadValue(4'd0),
        .aEnable(en2 & termLo), .aUp(1'b1), .aStickyClr(1'b0),
        .bCount(cntHi), .bCarry(carHi), .bTerminal(termHi), .bOverflowSticky(stHi));

    task automatic sample(input int unsigned dut, output logic [7:0] c, output logic ca,
                          output logic s, output logic t);
        case (dut)
            0:       begin c = {4'd0, cnt0}; ca = car0;  s = st0;  t = term0;  end
            1:       begin c = {4'd0, cnt1}; ca = car1;  s = st1;  t = term1;  end
            default: begin c = {cntHi, cntLo}; ca = carHi; s = stHi; t = termHi; end
        endcase
    endtask

    task automatic compare(input exp_t e);
        logic [7:0] c;
        logic       ca, s, t;
        sample(e.dut, c, ca, s, t);
        total++;
        if (c !== e.cnt || ca !== e.carry || s !== e.sticky || t !== e.term) begin
            bad++;
            $display("FAIL %s dut%0d: got cnt=%0d carry=%b sticky=%b term=%b, want cnt=%0d carry=%b sticky=%b term=%b",
                     e.name, e.dut, c, ca, s, t, e.cnt, e.carry, e.sticky, e.term);
        end
    endtask

    // Monitor: every registered update is checked just after the edge that produced it.
    always @(posedge BrdClk) begin
        #1;
        if (sb.size() > 0) compare(sb.pop_front());
    end

    function automatic exp_t mk(input int unsigned dut, input logic [7:0] c, input logic ca,
                                input logic s, input logic t, input string nm);
        exp_t e;
        e.dut = dut; e.cnt = c; e.carry = ca; e.sticky = s; e.term = t; e.name = nm;
        return e;
    endfunction

    task automatic drv0(input logic clr, input logic ld, input logic [3:0] lv, input logic en,
                        input logic up, input logic sc, input logic [3:0] eCnt,
                        input logic eCar, input logic eSt, input logic eTerm, input string nm);
        @(negedge BrdClk);
        clr0 = clr; ld0 = ld; lv0 = lv; en0 = en; up0 = up; sc0 = sc;
        sb.push_back(mk(0, 8'(eCnt), eCar, eSt, eTerm, nm));
    endtask

    task automatic drv1(input logic clr, input logic ld, input logic [3:0] lv, input logic en,
                        input logic up, input logic sc, input logic [3:0] eCnt,
                        input logic eCar, input logic eSt, input logic eTerm, input string nm);
        @(negedge BrdClk);
        clr1 = clr; ld1 = ld; lv1 = lv; en1 = en; up1 = up; sc1 = sc;
        sb.push_back(mk(1, 8'(eCnt), eCar, eSt, eTerm, nm));
    endtask

    initial begin
        #2;
        compare(mk(0, 8'd0, 1'b0, 1'b0, 1'b1, "rst0"));
        compare(mk(1, 8'd0, 1'b0, 1'b0, 1'b1, "rst1"));
        compare(mk(2, 8'd0, 1'b0, 1'b0, 1'b0, "rstCascade"));
        @(negedge BrdClk);
        aReset = 1'b0;

        // Down-wrap from reset, then an asynchronous reset in the middle of a cycle
        drv0(0, 0, 0, 1, 0, 0, 9, 1, 1, 0, "dnWrapFromRst");
        @(posedge BrdClk);
        #3;
        aReset = 1'b1;
        #1;
        compare(mk(0, 8'd0, 1'b0, 1'b0, 1'b1, "asyncRst"));
        @(negedge BrdClk);
        aReset = 1'b0;
        en0 = 1'b0;

        // Up count 0..9 then wrap
        for (int i = 1; i <= 10; i++)
            drv0(0, 0, 0, 1, 1, 0, 4'(i % 10), i == 10, i == 10, (i % 10) == 9, "upWrap");
        drv0(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "stkClr");

        // Load then down-wrap
        drv0(0, 1, 2, 0, 0, 0, 2, 0, 0, 0, "ld2");
        drv0(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, "dn1");
        drv0(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, "dn0");
        drv0(0, 0, 0, 1, 0, 0, 9, 1, 1, 0, "dn9");
        drv0(0, 0, 0, 1, 0, 0, 8, 0, 1, 0, "dn8");

        // Priority and load clamping
        drv0(1, 1, 5, 1, 1, 0, 0, 0, 1, 0, "prioClr");
        drv0(0, 1, 13, 0, 1, 0, 9, 0, 1, 1, "clamp13");
        drv0(0, 1, 4, 1, 1, 0, 4, 0, 1, 0, "ldNoStep");
        drv0(0, 1, 10, 0, 1, 0, 9, 0, 1, 1, "clamp10");
        drv0(0, 1, 15, 0, 1, 0, 9, 0, 1, 1, "clamp15");
        drv0(0, 1, 9, 0, 1, 0, 9, 0, 1, 1, "ld9");

        // Sticky clear racing a carry, then clearing alone
        drv0(0, 0, 0, 1, 1, 1, 0, 1, 1, 0, "stkRace");
        drv0(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "stkOnly");

        // Direction changes cycle by cycle; clear keeps sticky
        drv0(0, 0, 0, 1, 0, 0, 9, 1, 1, 0, "dirDn");
        drv0(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, "dirUp");
        drv0(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, "up1");
        drv0(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "clrKeepSticky");
        drv0(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "hold0");

        // Saturate mode
        drv1(0, 1, 7, 0, 1, 0, 7, 0, 0, 0, "sLd7");
        drv1(0, 0, 0, 1, 1, 0, 8, 0, 0, 0, "sUp8");
        drv1(0, 0, 0, 1, 1, 0, 9, 0, 0, 1, "sUp9");
        for (int i = 0; i < 3; i++)
            drv1(0, 0, 0, 1, 1, 0, 9, 1, 1, 1, "sHold9");
        drv1(0, 0, 0, 0, 1, 1, 9, 0, 0, 1, "sStkClr");
        drv1(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "sLd0");
        drv1(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, "sDnHold");
        drv1(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, "sDnHold2");
        drv1(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, "sUp1");
        drv1(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "sIdle");

        // Two-stage cascade over the full 8-bit range
        for (int i = 1; i <= 256; i++) begin
            @(negedge BrdClk);
            en2 = 1'b1;
            sb.push_back(mk(2, 8'(i), i == 256, i == 256, (8'(i) >> 4) == 8'd15, "cascade"));
        end
        @(negedge BrdClk);
        en2 = 1'b0;

        repeat (3) @(posedge BrdClk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want finish before it");
        $fatal(1, "watchdog");
    end

endmodule
